// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word requests to imem, buffers in-order
// responses in a small FIFO and hands {instr, instr_pc} to decode.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int unsigned TAGS = 2 * DEPTH;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned TW   = $clog2(TAGS);
  localparam int unsigned CW   = $clog2(TAGS + 1) + 1;

  typedef logic [CW-1:0] cnt_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  cnt_t                  out_q, out_d;
  cnt_t                  squash_q, squash_d;
  cnt_t                  cnt_q, cnt_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [TW-1:0]         th_q, th_d, tt_q, tt_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q       [TAGS];

  cnt_t live;
  logic accept, push, pop;

  // Squashed requests still occupy an outstanding slot but will never reach the FIFO.
  assign live           = out_q - squash_q;
  assign imem_req_valid = !rst && !redirect_valid && (out_q < cnt_t'(TAGS))
                          && ((cnt_q + live) < cnt_t'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign instr_valid = (cnt_q != '0) && !redirect_valid;
  assign instr       = (cnt_q != '0) ? fifo_data_q[rd_q] : '0;
  assign instr_pc    = (cnt_q != '0) ? fifo_pc_q[rd_q]   : '0;
  assign pop         = instr_valid && instr_ready;
  assign push        = imem_rsp_valid && !redirect_valid && (squash_q == '0);

  always_comb begin
    pc_d     = pc_q;
    squash_d = squash_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    th_d     = th_q;
    tt_d     = tt_q;
    out_d    = out_q + cnt_t'(accept) - cnt_t'(imem_rsp_valid);
    if (accept) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
      tt_d = tt_q + 1'b1;
    end
    if (imem_rsp_valid) th_d = th_q + 1'b1;
    if (redirect_valid) begin
      // Every request still in flight after this cycle's response is stale.
      pc_d     = redirect_pc & ~(ADDR_WIDTH'(3));
      squash_d = out_q - cnt_t'(imem_rsp_valid);
      cnt_d    = '0;
      rd_d     = '0;
      wr_d     = '0;
    end else begin
      if (imem_rsp_valid && (squash_q != '0)) squash_d = squash_q - 1'b1;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      squash_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      th_q     <= '0;
      tt_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      squash_q <= squash_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      th_q     <= th_d;
      tt_q     <= tt_d;
    end
  end

  // Storage is guarded by the counters, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_q] <= imem_rsp_data;
      fifo_pc_q[wr_q]   <= tag_q[th_q];
    end
    if (accept) tag_q[tt_q] <= pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && (out_q == '0)));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model with configurable latency and an in-order
// expected-PC scoreboard for everything delivered to decode.
module tb_fetch_unit;

  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        instr_valid;
  logic        instr_ready    = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RPC), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];

  int total = 0, bad = 0, cyc = 0, lat = 1, last_due = 0, emitted = 0;
  bit jitter = 0;
  logic rdy = 1, irdy = 1, redir = 0;
  logic [31:0] rpc = '0, exp_pc = RPC, last_emit_pc = '0;
  logic s_req_v, s_iv;
  logic [31:0] s_addr, s_ins, s_ipc;
  logic p_stuck = 0;
  logic [31:0] p_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample and score, then update the imem model.
  task automatic tick();
    logic rv;
    int   due;
    @(negedge clk);
    cyc++;
    imem_req_ready = rdy;
    instr_ready    = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rv = (mq.size() > 0) && (mq[0].due <= cyc) && (!jitter || $urandom_range(0, 3) != 0);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? word(mq[0].addr) : $urandom;
    #1;
    s_req_v = imem_req_valid;
    s_addr  = imem_req_addr;
    s_iv    = instr_valid;
    s_ins   = instr;
    s_ipc   = instr_pc;
    if (redir) begin
      chk("redir_no_instr", s_iv, 1'b0);
      chk("redir_no_req", s_req_v, 1'b0);
    end
    if (p_stuck && !redir) chk("addr_held", s_addr, p_addr);
    if (s_iv && irdy) begin
      chk("instr_pc", s_ipc, exp_pc);
      chk("instr_word", s_ins, word(exp_pc));
      last_emit_pc = s_ipc;
      emitted++;
      exp_pc = exp_pc + 32'd4;
    end
    p_stuck = s_req_v && !rdy;
    p_addr  = s_addr;
    @(posedge clk);
    if (s_req_v && rdy) begin
      due = cyc + (jitter ? int'($urandom_range(1, 3)) : lat);
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{addr: s_addr, due: due});
      last_due = due;
    end
    if (rv) mq.delete(0);
    if (redir) exp_pc = rpc & ~32'h3;
  endtask

  task automatic wait_emit(input string tag, input logic [31:0] exp);
    int e0;
    bit got;
    e0  = emitted;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = (emitted != e0);
    end
    chk({tag, "_seen"}, got, 1'b1);
    if (got) chk(tag, last_emit_pc, exp);
  endtask

  initial begin
    int e0;
    logic [31:0] a0;
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    #1 rst = 1'b0;

    // First fetches after reset, latency 1
    tick();
    chk("c1_req_valid", s_req_v, 1'b1);
    chk("c1_addr", s_addr, 32'h0);
    chk("c1_iv", s_iv, 1'b0);
    tick();
    chk("c2_addr", s_addr, 32'h4);
    chk("c2_iv", s_iv, 1'b0);
    tick();
    chk("c3_iv", s_iv, 1'b1);
    chk("c3_pc", s_ipc, 32'h0);

    // Sustained stream
    e0 = emitted;
    repeat (20) tick();
    chk("stream_rate", emitted - e0, 20);

    // Decode stall: FIFO fills, requests stop
    irdy = 0;
    repeat (10) tick();
    chk("stall_req_low", s_req_v, 1'b0);
    // Drain with imem blocked: exactly DEPTH words were held
    irdy = 1;
    rdy  = 0;
    e0 = emitted;
    repeat (8) tick();
    chk("stall_buffered", emitted - e0, D);

    // imem backpressure: address held, pc does not advance
    a0 = s_addr;
    repeat (5) tick();
    chk("bp_req_valid", s_req_v, 1'b1);
    chk("bp_addr", s_addr, a0);
    rdy = 1;
    tick();
    chk("bp_release_addr", s_addr, a0);
    tick();
    chk("bp_next_addr", s_addr, a0 + 32'd4);

    // Redirect with two requests in flight, latency 3
    lat = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() == 2) found = 1;
      else tick();
    end
    chk("two_in_flight", found, 1'b1);
    redir = 1;
    rpc = 32'h100;
    tick();
    redir = 0;
    wait_emit("redir_first", 32'h100);
    wait_emit("redir_second", 32'h104);

    // Redirect coincident with a response, then again while squashing
    lat = 2;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() >= 2 && mq[0].due <= cyc + 1) found = 1;
      else tick();
    end
    chk("coincident_setup", found, 1'b1);
    redir = 1;
    rpc = 32'h2000;
    tick();
    rpc = 32'h3003;
    tick();
    redir = 0;
    wait_emit("redir2_first", 32'h3000);
    wait_emit("redir2_second", 32'h3004);

    // PC wrap at the top of the address space
    lat = 1;
    redir = 1;
    rpc = 32'hFFFF_FFF9;
    tick();
    redir = 0;
    wait_emit("wrap0", 32'hFFFF_FFF8);
    wait_emit("wrap1", 32'hFFFF_FFFC);
    wait_emit("wrap2", 32'h0000_0000);

    // Randomized traffic: imem stalls, decode stalls, jittered latency, redirects
    jitter = 1;
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      irdy  = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 29) == 0);
      rpc   = $urandom;
      tick();
    end
    jitter = 0;
    redir  = 0;
    rdy    = 1;
    irdy   = 1;
    e0 = emitted;
    repeat (20) tick();
    chk("drain_progress", (emitted - e0) > 10, 1'b1);

    // Asynchronous reset mid-stream
    @(negedge clk);
    #2;
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("async_rst_req", imem_req_valid, 1'b0);
    chk("async_rst_iv", instr_valid, 1'b0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_pc", instr_pc, 32'h0);
    mq.delete();
    last_due = 0;
    exp_pc   = RPC;
    p_stuck  = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    wait_emit("post_rst_first", RPC);
    wait_emit("post_rst_second", RPC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
